// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: one shift stage per shamt bit, valid/ready, flush, sideband tag.
// Define SHIFTER_ROTATE_EN to enable ROL/ROR (modes 011/100); otherwise they are illegal.
module pipelined_barrel_shifter #(
    parameter  int WIDTH   = 32,
    parameter  int TAG_W   = 4,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [2:0]         in_mode,
    input  logic [TAG_W-1:0]   in_tag,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [TAG_W-1:0]   out_tag,
    output logic               out_illegal,
    output logic [SHAMT_W:0]   occupancy
);

    localparam logic [2:0] MODE_SLL = 3'b000;
    localparam logic [2:0] MODE_SRL = 3'b001;
    localparam logic [2:0] MODE_SRA = 3'b010;
`ifdef SHIFTER_ROTATE_EN
    localparam logic [2:0] MODE_ROL = 3'b011;
    localparam logic [2:0] MODE_ROR = 3'b100;
`endif

    if (WIDTH < 8 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("WIDTH must be a power of two in 8..64");
    end

    // Modes the datapath can execute in this build.
    function automatic logic mode_legal(input logic [2:0] m);
        logic ok;
        ok = (m == MODE_SLL) || (m == MODE_SRL) || (m == MODE_SRA);
`ifdef SHIFTER_ROTATE_EN
        ok = ok || (m == MODE_ROL) || (m == MODE_ROR);
`endif
        return ok;
    endfunction

    // One fixed-distance step; SRA refills from the current MSB, which
    // stays equal to the original sign bit across all stages.
    function automatic logic [WIDTH-1:0] shift_by(
        input logic [WIDTH-1:0] d,
        input logic [2:0]       m,
        input int               amt
    );
        logic [WIDTH-1:0] r;
        r = d;
        case (m)
            MODE_SLL: r = d << amt;
            MODE_SRL: r = d >> amt;
            MODE_SRA: r = (d >> amt)
                        | ({WIDTH{d[WIDTH-1]}} & ~({WIDTH{1'b1}} >> amt));
`ifdef SHIFTER_ROTATE_EN
            MODE_ROL: r = (d << amt) | (d >> (WIDTH - amt));
            MODE_ROR: r = (d >> amt) | (d << (WIDTH - amt));
`endif
            default:  r = d;
        endcase
        return r;
    endfunction

    // Per-stage pipeline registers
    logic [SHAMT_W-1:0][WIDTH-1:0]   data_q,  data_d;
    logic [SHAMT_W-1:0][SHAMT_W-1:0] shamt_q, shamt_d;
    logic [SHAMT_W-1:0][2:0]         mode_q,  mode_d;
    logic [SHAMT_W-1:0][TAG_W-1:0]   tag_q,   tag_d;
    logic [SHAMT_W-1:0]              ill_q,   ill_d;
    logic [SHAMT_W-1:0]              valid_q, valid_d;

    // Stage inputs: stage 0 from the port, stage k from stage k-1
    logic [SHAMT_W-1:0][WIDTH-1:0]   src_data;
    logic [SHAMT_W-1:0][SHAMT_W-1:0] src_shamt;
    logic [SHAMT_W-1:0][2:0]         src_mode;
    logic [SHAMT_W-1:0][TAG_W-1:0]   src_tag;
    logic [SHAMT_W-1:0]              src_ill;
    logic [SHAMT_W-1:0]              src_valid;

    logic stall;

    assign out_valid   = valid_q[SHAMT_W-1];
    assign out_data    = data_q[SHAMT_W-1];
    assign out_tag     = tag_q[SHAMT_W-1];
    assign out_illegal = ill_q[SHAMT_W-1];

    // Global stall: a blocked output freezes every stage.
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    // Route each stage's source: port for stage 0, previous register otherwise.
    always_comb begin
        src_data[0]  = in_data;
        src_shamt[0] = in_shamt;
        src_mode[0]  = in_mode;
        src_tag[0]   = in_tag;
        src_ill[0]   = !mode_legal(in_mode);
        src_valid[0] = in_valid && in_ready;
        for (int k = 1; k < SHAMT_W; k++) begin
            src_data[k]  = data_q[k-1];
            src_shamt[k] = shamt_q[k-1];
            src_mode[k]  = mode_q[k-1];
            src_tag[k]   = tag_q[k-1];
            src_ill[k]   = ill_q[k-1];
            src_valid[k] = valid_q[k-1];
        end
    end

    // Stage k shifts by 2^(SHAMT_W-1-k) when its shamt bit is set; hold on stall, flush kills valids.
    always_comb begin
        data_d  = data_q;
        shamt_d = shamt_q;
        mode_d  = mode_q;
        tag_d   = tag_q;
        ill_d   = ill_q;
        valid_d = valid_q;
        for (int k = 0; k < SHAMT_W; k++) begin
            if (!stall) begin
                if (src_shamt[k][SHAMT_W-1-k] && !src_ill[k]) begin
                    data_d[k] = shift_by(src_data[k], src_mode[k],
                                         1 << (SHAMT_W - 1 - k));
                end else begin
                    data_d[k] = src_data[k];
                end
                shamt_d[k] = src_shamt[k];
                mode_d[k]  = src_mode[k];
                tag_d[k]   = src_tag[k];
                ill_d[k]   = src_ill[k];
                valid_d[k] = src_valid[k];
            end
            if (flush) begin
                valid_d[k] = 1'b0;
            end
        end
    end

    // Pipeline state; reset clears valids and the visible result fields.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            shamt_q <= '0;
            mode_q  <= '0;
            tag_q   <= '0;
            ill_q   <= '0;
            valid_q <= '0;
        end else begin
            data_q  <= data_d;
            shamt_q <= shamt_d;
            mode_q  <= mode_d;
            tag_q   <= tag_d;
            ill_q   <= ill_d;
            valid_q <= valid_d;
        end
    end

    // Number of stages currently holding a live operation.
    always_comb begin
        occupancy = '0;
        for (int k = 0; k < SHAMT_W; k++) begin
            occupancy = occupancy + (SHAMT_W + 1)'(valid_q[k]);
        end
    end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Bench for pipelined_barrel_shifter: directed cases plus random traffic
// checked against a queue-based reference model.
module tb_pipelined_barrel_shifter;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_shamt;
    logic [2:0]  in_mode;
    logic [3:0]  in_tag;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_tag;
    logic        out_illegal;
    logic [5:0]  occupancy;

    pipelined_barrel_shifter #(.WIDTH(32), .TAG_W(4)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_shamt(in_shamt),
        .in_mode(in_mode), .in_tag(in_tag),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag),
        .out_illegal(out_illegal), .occupancy(occupancy)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  tag;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int pops   = 0;

    logic        s_ov, s_ill, s_ird, s_acc;
    logic [31:0] s_data;
    logic [3:0]  s_tag;
    logic [5:0]  s_occ;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic [3:0]  prev_tag;

    // Reference: each result bit picked straight from the mode's definition.
    function automatic exp_t model(logic [31:0] d, int s, logic [2:0] m, logic [3:0] t);
        exp_t e;
        bit   rot_ok;
`ifdef SHIFTER_ROTATE_EN
        rot_ok = 1'b1;
`else
        rot_ok = 1'b0;
`endif
        e.tag  = t;
        e.ill  = 1'b0;
        e.data = d;
        for (int i = 0; i < 32; i++) begin
            case (m)
                3'd0: e.data[i] = (i - s >= 0) ? d[i - s] : 1'b0;
                3'd1: e.data[i] = (i + s < 32) ? d[i + s] : 1'b0;
                3'd2: e.data[i] = (i + s < 32) ? d[i + s] : d[31];
                3'd3: if (rot_ok) e.data[i] = d[(i - s + 32) % 32];
                3'd4: if (rot_ok) e.data[i] = d[(i + s) % 32];
                default: ;
            endcase
        end
        if (m > 3'd4 || (!rot_ok && m > 3'd2)) begin
            e.ill  = 1'b1;
            e.data = d;
        end
        return e;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample and score at the falling edge, then step to just past the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clock);
        s_ov   = out_valid;
        s_data = out_data;
        s_tag  = out_tag;
        s_ill  = out_illegal;
        s_occ  = occupancy;
        s_ird  = in_ready;
        s_acc  = in_valid && in_ready && !flush && !reset;
        if (reset) begin
            q.delete();
            prev_stall = 1'b0;
        end else begin
            chk("occupancy_vs_model", occupancy, q.size());
            chk("in_ready", in_ready, !(out_valid && !out_ready));
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, prev_data);
                chk("hold_tag", out_tag, prev_tag);
            end
            if (out_valid && out_ready) begin
                chk("output_expected", q.size() > 0, 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    pops++;
                    chk("model_data", out_data, e.data);
                    chk("model_tag", out_tag, e.tag);
                    chk("model_illegal", out_illegal, e.ill);
                end
            end
            if (flush) q.delete();
            else if (s_acc) q.push_back(model(in_data, int'(in_shamt), in_mode, in_tag));
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_tag   = out_tag;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic rand_op();
        in_data  = $urandom;
        in_shamt = 5'($urandom_range(0, 31));
        in_mode  = 3'($urandom_range(0, 7));
        in_tag   = 4'($urandom_range(0, 15));
    endtask

    task automatic single_op(string nm, logic [2:0] m, logic [31:0] d,
                             logic [4:0] s, logic [3:0] t,
                             logic [31:0] xd, logic xi);
        int n;
        in_valid = 1'b1;
        in_mode  = m;
        in_data  = d;
        in_shamt = s;
        in_tag   = t;
        tick();
        chk({nm, "_accepted"}, s_acc, 1);
        in_valid = 1'b0;
        n = 0;
        do begin
            n++;
            tick();
        end while (!s_ov && n < 20);
        chk({nm, "_latency"}, n, 5);
        chk({nm, "_data"}, s_data, xd);
        chk({nm, "_tag"}, s_tag, t);
        chk({nm, "_illegal"}, s_ill, xi);
    endtask

    initial begin
        int sent, seen, stall_left, low, p0;
        logic [5:0]  maxocc;
        logic [31:0] d;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_mode   = '0;
        in_tag    = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_occupancy", occupancy, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_out_tag", out_tag, 0);
        chk("reset_out_illegal", out_illegal, 0);
        reset = 1'b0;

        single_op("sll31", 3'd0, 32'h0000_0001, 5'd31, 4'h3, 32'h8000_0000, 1'b0);
        single_op("sra4", 3'd2, 32'h8000_0000, 5'd4, 4'h5, 32'hF800_0000, 1'b0);
        single_op("srl4", 3'd1, 32'h8000_0000, 5'd4, 4'h6, 32'h0800_0000, 1'b0);
        single_op("sra0", 3'd2, 32'h8000_0000, 5'd0, 4'h7, 32'h8000_0000, 1'b0);
`ifdef SHIFTER_ROTATE_EN
        single_op("ror1", 3'd4, 32'h0000_0001, 5'd1, 4'h8, 32'h8000_0000, 1'b0);
        single_op("rol4", 3'd3, 32'hF000_0001, 5'd4, 4'h9, 32'h0000_001F, 1'b0);
        for (int m = 0; m < 5; m++) begin
`else
        single_op("ror1", 3'd4, 32'h0000_0001, 5'd1, 4'h8, 32'h0000_0001, 1'b1);
        single_op("rol4", 3'd3, 32'hF000_0001, 5'd4, 4'h9, 32'hF000_0001, 1'b1);
        for (int m = 0; m < 3; m++) begin
`endif
            d = $urandom;
            single_op("shamt0", 3'(m), d, 5'd0, 4'(m), d, 1'b0);
        end
        for (int m = 5; m < 8; m++) begin
            d = $urandom;
            single_op("illegal", 3'(m), d, 5'($urandom_range(1, 31)), 4'(m), d, 1'b1);
        end

        // Back-to-back stream with a 3-cycle output stall at the first result
        sent = 0; seen = 0; stall_left = 0; low = 0; maxocc = '0; p0 = pops;
        in_valid = 1'b1;
        rand_op();
        for (int c = 0; c < 60 && (pops - p0) < 8; c++) begin
            if (out_valid && seen == 0) begin
                seen = 1;
                stall_left = 3;
            end
            out_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            tick();
            if (!s_ird) low++;
            if (s_occ > maxocc) maxocc = s_occ;
            if (s_acc) begin
                sent++;
                if (sent < 8) rand_op();
                else in_valid = 1'b0;
            end
        end
        chk("stream_results", pops - p0, 8);
        chk("stream_sent", sent, 8);
        chk("stream_in_ready_low", low, 3);
        chk("stream_max_occ", maxocc <= 6'd5, 1);
        chk("stream_empty", q.size(), 0);

        // Random traffic with random backpressure and occasional flush
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 49) == 0);
            rand_op();
            tick();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (12) tick();
        chk("random_drained", q.size(), 0);

        // Reset with three operations in flight
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            rand_op();
            tick();
        end
        in_valid = 1'b0;
        @(negedge clock);
        chk("occ_before_reset", occupancy, 3);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_valid", out_valid, 0);
        chk("async_reset_occ", occupancy, 0);
        chk("async_reset_data", out_data, 0);
        tick();
        reset = 1'b0;
        seen = 0;
        repeat (10) begin
            tick();
            if (s_ov) seen++;
        end
        chk("no_stale_after_reset", seen, 0);

        // Flush with a full, stalled pipeline; the flush-cycle input is dropped
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            rand_op();
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("occ_full", s_occ, 5);
        chk("full_out_valid", s_ov, 1);
        flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        rand_op();
        tick();
        flush = 1'b0; in_valid = 1'b0;
        tick();
        chk("flush_occ", s_occ, 0);
        chk("flush_out_valid", s_ov, 0);
        seen = 0;
        repeat (8) begin
            tick();
            if (s_ov) seen++;
        end
        chk("no_output_after_flush", seen, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
